// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle RV32I core: sequences fetch/decode/execute/memory/writeback
// over a shared ALU and a single memory port, with illegal-opcode and memory-timeout traps.
module multicycle_ctrl #(
    parameter int TIMEOUT = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       alu_zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_we,
    output logic       pc_we,
    output logic       pc_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic       alu_op_sel,
    output logic [1:0] result_src,
    output logic       reg_we,
    output logic       illegal,
    output logic       timeout,
    output logic [3:0] state
);
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3,
        S_MEMWR = 4'd4, S_WBMEM = 4'd5, S_EXR = 4'd6, S_EXI = 4'd7,
        S_WBALU = 4'd8, S_BRANCH = 4'd9, S_JAL = 4'd10, S_TRAP = 4'd11
    } state_t;

    state_t        cur, nxt;
    logic [CW-1:0] wait_cnt;
    logic          req_state, expired;

    assign state     = cur;
    assign req_state = (cur == S_FETCH) || (cur == S_MEMRD) || (cur == S_MEMWR);
    // mem_ready in the final allowed cycle still wins over the timeout trap
    assign expired   = req_state && !mem_ready && (wait_cnt == LAST);

    always_comb begin
        nxt = cur;
        case (cur)
            S_FETCH:  if (mem_ready) nxt = S_DECODE; else if (expired) nxt = S_TRAP;
            S_DECODE: begin
                case (opcode)
                    OP_LOAD, OP_STORE: nxt = S_MEMADR;
                    OP_RTYPE:          nxt = S_EXR;
                    OP_ITYPE:          nxt = S_EXI;
                    OP_BRANCH:         nxt = S_BRANCH;
                    OP_JAL:            nxt = S_JAL;
                    default:           nxt = S_TRAP;
                endcase
            end
            S_MEMADR: nxt = (opcode == OP_LOAD) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) nxt = S_WBMEM; else if (expired) nxt = S_TRAP;
            S_MEMWR:  if (mem_ready) nxt = S_FETCH; else if (expired) nxt = S_TRAP;
            S_EXR, S_EXI: nxt = S_WBALU;
            S_WBMEM, S_WBALU, S_BRANCH, S_JAL: nxt = S_FETCH;
            S_TRAP:   nxt = S_TRAP;
            default:  nxt = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
            illegal  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            cur <= nxt;
            // counter only runs while a request is stalled; any state change clears it
            if (req_state && !mem_ready && nxt == cur)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (cur == S_DECODE && nxt == S_TRAP) illegal <= 1'b1;
            if (expired) timeout <= 1'b1;
        end
    end

    always_comb begin
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 1'b0;
        alu_src_a    = 2'b00;
        alu_src_b    = 2'b00;
        alu_op_sel   = 1'b0;
        result_src   = 2'b00;
        reg_we       = 1'b0;
        if (!rst) begin
            case (cur)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we     = 1'b1;
                        pc_we     = 1'b1;
                        alu_src_b = 2'b10;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                end
                S_MEMRD: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                end
                S_MEMWR: begin
                    mem_req      = 1'b1;
                    mem_we       = 1'b1;
                    mem_addr_sel = 1'b1;
                end
                S_WBMEM: begin
                    reg_we     = 1'b1;
                    result_src = 2'b01;
                end
                S_EXR: begin
                    alu_src_a  = 2'b10;
                    alu_op_sel = 1'b1;
                end
                S_EXI: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    alu_op_sel = 1'b1;
                end
                S_WBALU: reg_we = 1'b1;
                S_BRANCH: begin
                    alu_src_a  = 2'b10;
                    alu_op_sel = 1'b1;
                    pc_we      = alu_zero;
                    pc_src     = 1'b1;
                end
                S_JAL: begin
                    reg_we     = 1'b1;
                    result_src = 2'b10;
                    pc_we      = 1'b1;
                    pc_src     = 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each test queues per-cycle stimulus plus expected
// outputs, then drains the queue cycle by cycle comparing against the DUT.
module tb_multicycle_ctrl;
    logic       clk, rst, alu_zero, mem_ready;
    logic [6:0] opcode;
    logic       mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src, alu_op_sel, reg_we;
    logic       illegal, timeout;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0] st;
        logic       req, we, asel, irwe, pcwe, pcsrc;
        logic [1:0] a, b;
        logic       opsel;
        logic [1:0] rs;
        logic       regwe, ill, to;
    } out_t;

    typedef struct packed {
        logic       rst, rdy, z;
        logic [6:0] op;
        out_t       exp;
    } step_t;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, ADD = 7'b0110011;
    localparam logic [6:0] ADDI = 7'b0010011, BEQ = 7'b1100011, JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1110011;

    step_t sb[$];
    step_t s;
    out_t  obs;
    int    n_cmp = 0, n_err = 0;

    multicycle_ctrl #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
        .pc_we(pc_we), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op_sel(alu_op_sel), .result_src(result_src), .reg_we(reg_we),
        .illegal(illegal), .timeout(timeout), .state(state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Expected outputs for a state, straight from the state table
    function automatic out_t ex(logic [3:0] st, logic rdy, logic z, logic ill, logic to);
        out_t o = '0;
        o.st = st; o.ill = ill; o.to = to;
        case (st)
            4'd0:  begin o.req = 1; if (rdy) begin o.irwe = 1; o.pcwe = 1; o.b = 2'b10; end end
            4'd1:  begin o.a = 2'b01; o.b = 2'b01; end
            4'd2:  begin o.a = 2'b10; o.b = 2'b01; end
            4'd3:  begin o.req = 1; o.asel = 1; end
            4'd4:  begin o.req = 1; o.we = 1; o.asel = 1; end
            4'd5:  begin o.regwe = 1; o.rs = 2'b01; end
            4'd6:  begin o.a = 2'b10; o.opsel = 1; end
            4'd7:  begin o.a = 2'b10; o.b = 2'b01; o.opsel = 1; end
            4'd8:  o.regwe = 1;
            4'd9:  begin o.a = 2'b10; o.opsel = 1; o.pcwe = z; o.pcsrc = 1; end
            4'd10: begin o.regwe = 1; o.rs = 2'b10; o.pcwe = 1; o.pcsrc = 1; end
            default: ;
        endcase
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.st = state; o.req = mem_req; o.we = mem_we; o.asel = mem_addr_sel;
        o.irwe = ir_we; o.pcwe = pc_we; o.pcsrc = pc_src; o.a = alu_src_a; o.b = alu_src_b;
        o.opsel = alu_op_sel; o.rs = result_src; o.regwe = reg_we; o.ill = illegal;
        o.to = timeout;
        return o;
    endfunction

    task automatic push(logic r, logic rdy, logic z, logic [6:0] op, out_t e);
        step_t t;
        t.rst = r; t.rdy = rdy; t.z = z; t.op = op; t.exp = e;
        sb.push_back(t);
    endtask

    task automatic test_reset();
        push(1, 0, 0, 7'd0, '0);
        push(1, 1, 0, 7'd0, '0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.rst; mem_ready = s.rdy; alu_zero = s.z; opcode = s.op;
            #1; obs = sample(); n_cmp++;
            if (obs !== s.exp) begin
                n_err++; $display("FAIL reset: got %h expected %h", obs, s.exp);
            end
        end
    endtask

    task automatic test_add();
        push(0, 1, 0, ADD, ex(0, 1, 0, 0, 0));
        push(0, 0, 0, ADD, ex(1, 0, 0, 0, 0));
        push(0, 0, 0, ADD, ex(6, 0, 0, 0, 0));
        push(0, 0, 0, ADD, ex(8, 0, 0, 0, 0));
        push(0, 1, 0, ADDI, ex(0, 1, 0, 0, 0));
        push(0, 0, 0, ADDI, ex(1, 0, 0, 0, 0));
        push(0, 0, 0, ADDI, ex(7, 0, 0, 0, 0));
        push(0, 0, 0, ADDI, ex(8, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.rst; mem_ready = s.rdy; alu_zero = s.z; opcode = s.op;
            #1; obs = sample(); n_cmp++;
            if (obs !== s.exp) begin
                n_err++; $display("FAIL alu_ops: got %h expected %h", obs, s.exp);
            end
        end
    endtask

    task automatic test_load_store();
        push(0, 1, 0, LW, ex(0, 1, 0, 0, 0));
        push(0, 0, 0, LW, ex(1, 0, 0, 0, 0));
        push(0, 0, 0, LW, ex(2, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) push(0, 0, 0, LW, ex(3, 0, 0, 0, 0));
        push(0, 1, 0, LW, ex(3, 1, 0, 0, 0));
        push(0, 0, 0, LW, ex(5, 0, 0, 0, 0));
        push(0, 1, 0, SW, ex(0, 1, 0, 0, 0));
        push(0, 0, 0, SW, ex(1, 0, 0, 0, 0));
        push(0, 0, 0, SW, ex(2, 0, 0, 0, 0));
        push(0, 1, 0, SW, ex(4, 1, 0, 0, 0));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.rst; mem_ready = s.rdy; alu_zero = s.z; opcode = s.op;
            #1; obs = sample(); n_cmp++;
            if (obs !== s.exp) begin
                n_err++; $display("FAIL load_store: got %h expected %h", obs, s.exp);
            end
        end
    endtask

    task automatic test_branch_jal();
        push(0, 1, 0, BEQ, ex(0, 1, 0, 0, 0));
        push(0, 0, 0, BEQ, ex(1, 0, 0, 0, 0));
        push(0, 0, 1, BEQ, ex(9, 0, 1, 0, 0));
        push(0, 1, 0, BEQ, ex(0, 1, 0, 0, 0));
        push(0, 0, 0, BEQ, ex(1, 0, 0, 0, 0));
        push(0, 0, 0, BEQ, ex(9, 0, 0, 0, 0));
        push(0, 1, 0, JAL, ex(0, 1, 0, 0, 0));
        push(0, 0, 0, JAL, ex(1, 0, 0, 0, 0));
        push(0, 0, 0, JAL, ex(10, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.rst; mem_ready = s.rdy; alu_zero = s.z; opcode = s.op;
            #1; obs = sample(); n_cmp++;
            if (obs !== s.exp) begin
                n_err++; $display("FAIL branch_jal: got %h expected %h", obs, s.exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        push(0, 1, 0, LW, ex(0, 1, 0, 0, 0));
        push(0, 0, 0, LW, ex(1, 0, 0, 0, 0));
        push(0, 0, 0, LW, ex(2, 0, 0, 0, 0));
        push(0, 0, 0, LW, ex(3, 0, 0, 0, 0));
        push(0, 0, 0, LW, ex(3, 0, 0, 0, 0));
        push(1, 0, 0, LW, '0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.rst; mem_ready = s.rdy; alu_zero = s.z; opcode = s.op;
            #1; obs = sample(); n_cmp++;
            if (obs !== s.exp) begin
                n_err++; $display("FAIL reset_mid: got %h expected %h", obs, s.exp);
            end
        end
    endtask

    task automatic test_timeout_ready();
        for (int i = 0; i < 3; i++) push(0, 0, 0, ADD, ex(0, 0, 0, 0, 0));
        push(0, 1, 0, ADD, ex(0, 1, 0, 0, 0));
        push(0, 0, 0, ADD, ex(1, 0, 0, 0, 0));
        push(0, 0, 0, ADD, ex(6, 0, 0, 0, 0));
        push(0, 0, 0, ADD, ex(8, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.rst; mem_ready = s.rdy; alu_zero = s.z; opcode = s.op;
            #1; obs = sample(); n_cmp++;
            if (obs !== s.exp) begin
                n_err++; $display("FAIL timeout_ready: got %h expected %h", obs, s.exp);
            end
        end
    endtask

    task automatic test_illegal();
        push(0, 1, 0, BAD, ex(0, 1, 0, 0, 0));
        push(0, 0, 0, BAD, ex(1, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) push(0, 1, 1, BAD, ex(11, 1, 1, 1, 0));
        push(1, 0, 0, BAD, '0);
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.rst; mem_ready = s.rdy; alu_zero = s.z; opcode = s.op;
            #1; obs = sample(); n_cmp++;
            if (obs !== s.exp) begin
                n_err++; $display("FAIL illegal: got %h expected %h", obs, s.exp);
            end
        end
    endtask

    task automatic test_timeout();
        for (int i = 0; i < 4; i++) push(0, 0, 0, ADD, ex(0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) push(0, 1, 0, ADD, ex(11, 1, 0, 0, 1));
        push(1, 0, 0, ADD, '0);
        push(0, 1, 0, ADD, ex(0, 1, 0, 0, 0));
        push(0, 0, 0, ADD, ex(1, 0, 0, 0, 0));
        while (sb.size() > 0) begin
            s = sb.pop_front();
            @(negedge clk); rst = s.rst; mem_ready = s.rdy; alu_zero = s.z; opcode = s.op;
            #1; obs = sample(); n_cmp++;
            if (obs !== s.exp) begin
                n_err++; $display("FAIL timeout: got %h expected %h", obs, s.exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b0; alu_zero = 1'b0; opcode = 7'd0;
        test_reset();
        test_add();
        test_load_store();
        test_branch_jal();
        test_reset_mid();
        test_timeout_ready();
        test_illegal();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
